// File: rtl/seq_divider_param.sv
// seq_divider_param: multi-cycle restoring divider with signed/unsigned mode, start/ready handshake and divide-by-zero flag
module seq_divider_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_rem, r_dvd, r_dvs, r_quo, r_rmd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q, r_neg_r, r_dbz;
  logic             w_a_neg, w_b_neg, w_ge, w_zero, w_last;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_trial, w_rem_n, w_dvd_n;
  logic [WIDTH:0]   w_sh;
  assign w_a_neg = is_signed & dividend[WIDTH-1];
  assign w_b_neg = is_signed & divisor[WIDTH-1];
  assign w_a_mag = w_a_neg ? -dividend : dividend;
  assign w_b_mag = w_b_neg ? -divisor : divisor;
  assign w_zero  = divisor == '0;
  assign w_last  = r_cnt == CNT_W'(1);
  assign w_sh    = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge    = w_sh >= {1'b0, r_dvs};
  assign w_trial = w_sh[WIDTH-1:0] - r_dvs;
  assign w_rem_n = w_ge ? w_trial : w_sh[WIDTH-1:0];
  assign w_dvd_n = {r_dvd[WIDTH-2:0], w_ge};
  assign busy        = r_state == RUN;
  assign ready       = r_state == DONE;
  assign quotient    = r_quo;
  assign remainder   = r_rmd;
  assign div_by_zero = r_dbz;
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // next-state: accept in IDLE, iterate WIDTH cycles in RUN, single DONE cycle
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = start ? (w_zero ? DONE : RUN) : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // datapath: latch magnitudes on accept, one quotient bit per RUN cycle, sign-fix on the final step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quo   <= '0;
      r_rmd   <= '0;
      r_dbz   <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_rem   <= '0;
      r_dvd   <= w_a_mag;
      r_dvs   <= w_b_mag;
      r_cnt   <= CNT_W'(WIDTH);
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      if (w_zero) begin
        r_quo <= '1;
        r_rmd <= dividend;
        r_dbz <= 1'b1;
      end
    end else if (r_state == RUN) begin
      r_rem <= w_rem_n;
      r_dvd <= w_dvd_n;
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last) begin
        r_quo <= r_neg_q ? -w_dvd_n : w_dvd_n;
        r_rmd <= r_neg_r ? -w_rem_n : w_rem_n;
        r_dbz <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider_param.sv
// tb_seq_divider_param: randomized and directed checks of 32- and 8-bit dividers against an arithmetic model
module tb_seq_divider_param;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic        sel8 = 1'b0;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        busy32, ready32, dbz32, busy8, ready8, dbz8;
  logic [31:0] q32, r32;
  logic [7:0]  q8, r8;
  logic        busy_m, ready_m;
  logic [63:0] q_m, r_m, z_m;
  int          n_tests = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  seq_divider_param #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start & ~sel8), .is_signed(is_signed),
    .dividend(dividend[31:0]), .divisor(divisor[31:0]), .busy(busy32), .ready(ready32),
    .quotient(q32), .remainder(r32), .div_by_zero(dbz32));
  seq_divider_param #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start & sel8), .is_signed(is_signed),
    .dividend(dividend[7:0]), .divisor(divisor[7:0]), .busy(busy8), .ready(ready8),
    .quotient(q8), .remainder(r8), .div_by_zero(dbz8));
  assign busy_m  = sel8 ? busy8 : busy32;
  assign ready_m = sel8 ? ready8 : ready32;
  assign q_m     = sel8 ? {56'b0, q8} : {32'b0, q32};
  assign r_m     = sel8 ? {56'b0, r8} : {32'b0, r32};
  assign z_m     = {63'b0, sel8 ? dbz8 : dbz32};
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void ref_div(input int w, input logic [63:0] a, input logic [63:0] b, input bit s,
                                  output logic [63:0] q, output logic [63:0] r, output logic [63:0] z);
    logic [63:0] m;
    longint      sa, sb, lq, lr;
    m = (64'd1 << w) - 64'd1;
    if ((b & m) == 64'd0) begin
      q = m;
      r = a & m;
      z = 64'd1;
    end else begin
      if (s) begin
        sa = longint'(a << (64 - w)) >>> (64 - w);
        sb = longint'(b << (64 - w)) >>> (64 - w);
      end else begin
        sa = longint'(a & m);
        sb = longint'(b & m);
      end
      lq = sa / sb;
      lr = sa % sb;
      q = 64'(lq) & m;
      r = 64'(lr) & m;
      z = 64'd0;
    end
  endfunction
  task automatic run_op(input bit w8, input bit s, input logic [63:0] a, input logic [63:0] b, input bit disturb);
    int          w, k, nb;
    logic [63:0] eq, er, ez;
    w = w8 ? 8 : 32;
    ref_div(w, a, b, s, eq, er, ez);
    @(negedge clk);
    sel8 = w8;
    is_signed = s;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    nb = 0;
    while (!ready_m && k < 200) begin
      if (busy_m) nb++;
      if (disturb && k == 4) begin
        dividend = {$urandom, $urandom};
        divisor = {$urandom, $urandom};
        is_signed = ~s;
        start = 1'b1;
      end
      if (disturb && k == 5) start = 1'b0;
      @(posedge clk);
      #1 k++;
    end
    start = 1'b0;
    check("latency", 64'(k + 1), ez[0] ? 64'd1 : 64'(w + 1));
    check("busy_cycles", 64'(nb), ez[0] ? 64'd0 : 64'(w));
    check("busy_at_ready", 64'(busy_m), 64'd0);
    check("quotient", q_m, eq);
    check("remainder", r_m, er);
    check("div_by_zero", z_m, ez);
    @(posedge clk);
    #1 check("ready_pulse", 64'(ready_m), 64'd0);
    check("hold_quotient", q_m, eq);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int          j, nr;
    bit          s, w8;
    logic [63:0] a, b;
    #3;
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_ready", 64'(ready32), 64'd0);
    check("rst_q", {32'b0, q32}, 64'd0);
    check("rst_r", {32'b0, r32}, 64'd0);
    check("rst_dbz", 64'(dbz32), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(0, 0, 64'd7, 64'd2, 0);
    run_op(0, 1, 64'hFFFFFFF9, 64'd2, 0);
    run_op(0, 1, 64'd7, 64'hFFFFFFFE, 0);
    run_op(0, 1, 64'h80000000, 64'hFFFFFFFF, 0);
    run_op(0, 0, 64'h80000000, 64'hFFFFFFFF, 0);
    run_op(0, 1, 64'h1234, 64'd0, 0);
    run_op(0, 0, 64'd10, 64'd3, 0);
    run_op(0, 0, 64'd1000, 64'd9, 1);
    run_op(1, 0, 64'd200, 64'd7, 0);
    run_op(1, 1, 64'h80, 64'hFF, 0);
    @(negedge clk);
    sel8 = 1'b0;
    is_signed = 1'b0;
    dividend = 64'd100;
    divisor = 64'd7;
    start = 1'b1;
    @(posedge clk);
    #1 j = 0;
    while (!ready_m && j < 200) begin
      @(posedge clk);
      #1 j++;
    end
    check("b2b_first_q", q_m, 64'd14);
    j = 0;
    while (!busy_m && j < 10) begin
      @(posedge clk);
      #1 j++;
    end
    check("reissue_gap", 64'(j), 64'd2);
    start = 1'b0;
    j = 0;
    while (!ready_m && j < 200) begin
      @(posedge clk);
      #1 j++;
    end
    check("b2b_second_r", r_m, 64'd2);
    @(negedge clk);
    dividend = 64'd1000;
    divisor = 64'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy32), 64'd0);
    check("mid_rst_q", {32'b0, q32}, 64'd0);
    check("mid_rst_r", {32'b0, r32}, 64'd0);
    check("mid_rst_dbz", 64'(dbz32), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    nr = 0;
    repeat (50) begin
      @(posedge clk);
      #1 if (ready32) nr++;
    end
    check("no_ready_after_rst", 64'(nr), 64'd0);
    for (int i = 0; i < 60; i++) begin
      w8 = (i % 4) == 0;
      s = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 5));
        2: b = '1;
        3: a = 64'd1 << (w8 ? 7 : 31);
        4: b = b >> (w8 ? 4 : 20);
        default: ;
      endcase
      run_op(w8, s, a, b, i % 7 == 3);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
